// File: rtl/router_egress_reader_pkg.sv
// Shared router definitions: default widths, timeout, framing FSM encoding
// and header field layout.
package router_egress_reader_pkg;

   localparam int DW_DEF      = 8;
   localparam int LENW_DEF    = 6;
   localparam int TIMEOUT_DEF = 30;

   // Header layout: [DW-1:LEN_LSB] payload length, [ADDR_W-1:0] address.
   localparam int LEN_LSB = 2;
   localparam int ADDR_W  = 2;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      BODY = 2'd1,
      PAR  = 2'd2
   } state_t;

endpackage

// File: rtl/router_egress_reader_if.sv
// FIFO-side and destination-side signals of one router egress port.
interface router_egress_reader_if
   import router_egress_reader_pkg::*;
#(
   parameter int DW = DW_DEF
);

   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          fifo_reen;
   logic          soft_rst;
   logic          dest_rd;
   logic [DW-1:0] dout;
   logic          vld_out;
   logic          sop;
   logic          eop;
   logic          parity_err;
   logic          busy;

   modport master (
      input  fifo_empty, fifo_dout, dest_rd,
      output fifo_reen, soft_rst, dout, vld_out, sop, eop, parity_err, busy
   );

   modport slave (
      output fifo_empty, fifo_dout, dest_rd,
      input  fifo_reen, soft_rst, dout, vld_out, sop, eop, parity_err, busy
   );

endinterface

// File: rtl/router_timeout_ctr.sv
// Stall watchdog: counts enabled cycles and pulses expire on the LIMIT-th
// consecutive one; clr restarts the count.
module router_timeout_ctr
   import router_egress_reader_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] tcnt;

   assign expire = en && (tcnt == CW'(LIMIT - 1));

   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt <= '0;
      end else if (clr || expire) begin
         tcnt <= '0;
      end else if (en) begin
         tcnt <= tcnt + 1'b1;
      end
   end

endmodule

// File: rtl/router_egress_reader.sv
// Read-side controller for one router output-port FIFO: pops bytes, rebuilds
// header/payload/parity framing, checks parity and drops stalled packets.
module router_egress_reader
   import router_egress_reader_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int LENW    = LENW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic                   clk,
   input logic                   rst,
   router_egress_reader_if.master bus
);

   state_t          state;
   logic            rd_pend;
   logic [DW-1:0]   dout_q;
   logic            vld_q;
   logic            sop_q;
   logic            eop_q;
   logic            perr_q;
   logic            busy_q;
   logic [LENW-1:0] cnt;
   logic [DW-1:0]   par;
   logic [DW-1:0]   exp_par;

   logic            stall;
   logic            accept;
   logic            expire;
   logic            reen;
   logic [LENW-1:0] hdr_len;

   assign stall   = vld_q && !bus.dest_rd;
   assign accept  = vld_q && bus.dest_rd;
   assign hdr_len = bus.fifo_dout[LEN_LSB +: LENW];

   // NOTE: reen is qualified by rst so the FIFO sees no pop while reset is held,
   // even though the reset itself is asynchronous to the registers.
   assign reen = rst && !bus.fifo_empty && !rd_pend && !expire && (!vld_q || bus.dest_rd);

   router_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .en     (stall),
      .clr    (accept || !vld_q),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= HDR;
         rd_pend <= 1'b0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         perr_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt     <= '0;
         par     <= '0;
         exp_par <= '0;
      end else if (expire) begin
         // Timeout drops the packet; any byte still in flight is discarded.
         state   <= HDR;
         rd_pend <= 1'b0;
         vld_q   <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         perr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         rd_pend <= reen;
         perr_q  <= accept && eop_q && (dout_q != exp_par);
         if (accept && eop_q) begin
            busy_q <= 1'b0;
         end
         if (rd_pend) begin
            dout_q <= bus.fifo_dout;
            vld_q  <= 1'b1;
            unique case (state)
               HDR: begin
                  sop_q  <= 1'b1;
                  eop_q  <= 1'b0;
                  busy_q <= 1'b1;
                  cnt    <= hdr_len;
                  par    <= bus.fifo_dout;
                  state  <= (hdr_len != '0) ? BODY : PAR;
               end
               BODY: begin
                  sop_q <= 1'b0;
                  eop_q <= 1'b0;
                  par   <= par ^ bus.fifo_dout;
                  cnt   <= cnt - 1'b1;
                  if (cnt == LENW'(1)) begin
                     state <= PAR;
                  end
               end
               PAR: begin
                  sop_q   <= 1'b0;
                  eop_q   <= 1'b1;
                  exp_par <= par;
                  state   <= HDR;
               end
               default: state <= HDR;
            endcase
         end else if (accept) begin
            vld_q <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
         end
      end
   end

   assign bus.fifo_reen  = reen;
   assign bus.soft_rst   = expire;
   assign bus.dout       = dout_q;
   assign bus.vld_out    = vld_q;
   assign bus.sop        = sop_q;
   assign bus.eop        = eop_q;
   assign bus.parity_err = perr_q;
   assign bus.busy       = busy_q;

endmodule
